// File: rtl/cmd_stream_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-Stream command sources into one
// registered command stream; a grant is held from the first beat until the tlast beat.
module cmd_stream_arbiter #(
    parameter int CMD_STREAM_WIDTH = 64
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        s0_cmd_axis_tvalid,
    output logic                        s0_cmd_axis_tready,
    input  logic                        s0_cmd_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s0_cmd_axis_tdata,
    input  logic                        s1_cmd_axis_tvalid,
    output logic                        s1_cmd_axis_tready,
    input  logic                        s1_cmd_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s1_cmd_axis_tdata,
    output logic                        m_cmd_axis_tvalid,
    input  logic                        m_cmd_axis_tready,
    output logic                        m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic [1:0]                  dbgGrant
);

    // Encoding doubles as the one-hot debug grant vector.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GRANT0 = 2'b01;
    localparam logic [1:0] ST_GRANT1 = 2'b10;

    logic [1:0]                  state_r;
    logic [1:0]                  state_next_s;
    logic                        last_grant_r;
    logic                        last_grant_next_s;
    logic                        m_valid_r;
    logic                        m_last_r;
    logic [CMD_STREAM_WIDTH-1:0] m_data_r;
    logic                        out_ready_s;
    logic                        accept0_s;
    logic                        accept1_s;
    logic                        beat_last_s;
    logic [CMD_STREAM_WIDTH-1:0] beat_data_s;

    // Source readiness depends only on state and the output side, never on tvalid.
    assign out_ready_s        = !m_valid_r || m_cmd_axis_tready;
    assign s0_cmd_axis_tready = (state_r == ST_GRANT0) && out_ready_s;
    assign s1_cmd_axis_tready = (state_r == ST_GRANT1) && out_ready_s;
    assign accept0_s          = s0_cmd_axis_tvalid && s0_cmd_axis_tready;
    assign accept1_s          = s1_cmd_axis_tvalid && s1_cmd_axis_tready;

    assign m_cmd_axis_tvalid  = m_valid_r;
    assign m_cmd_axis_tlast   = m_last_r;
    assign m_cmd_axis_tdata   = m_data_r;
    assign dbgGrant           = state_r;

    // Select the beat being accepted this cycle from the granted source.
    always_comb begin
        beat_data_s = '0;
        beat_last_s = 1'b0;
        if (accept0_s) begin
            beat_data_s = s0_cmd_axis_tdata;
            beat_last_s = s0_cmd_axis_tlast;
        end else if (accept1_s) begin
            beat_data_s = s1_cmd_axis_tdata;
            beat_last_s = s1_cmd_axis_tlast;
        end else begin
            beat_data_s = '0;
            beat_last_s = 1'b0;
        end
    end

    // Grant FSM: ties go to the port that did not finish the previous packet.
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (s0_cmd_axis_tvalid && s1_cmd_axis_tvalid) begin
                    state_next_s = last_grant_r ? ST_GRANT0 : ST_GRANT1;
                end else if (s0_cmd_axis_tvalid) begin
                    state_next_s = ST_GRANT0;
                end else if (s1_cmd_axis_tvalid) begin
                    state_next_s = ST_GRANT1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT0: begin
                if (accept0_s && s0_cmd_axis_tlast) begin
                    state_next_s      = ST_IDLE;
                    last_grant_next_s = 1'b0;
                end else begin
                    state_next_s = ST_GRANT0;
                end
            end
            ST_GRANT1: begin
                if (accept1_s && s1_cmd_axis_tlast) begin
                    state_next_s      = ST_IDLE;
                    last_grant_next_s = 1'b1;
                end else begin
                    state_next_s = ST_GRANT1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Output register: load wins over drain, data held while stalled.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
        end else if (accept0_s || accept1_s) begin
            m_valid_r <= 1'b1;
            m_last_r  <= beat_last_s;
            m_data_r  <= beat_data_s;
        end else if (m_valid_r && m_cmd_axis_tready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed, table-driven bench for cmd_stream_arbiter with an in-order beat scoreboard
// and a randomised-backpressure packet at the end.
module tb_cmd_stream_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s0_valid = 1'b0, s0_ready, s0_last = 1'b0;
    logic [63:0] s0_data = 64'h0;
    logic        s1_valid = 1'b0, s1_ready, s1_last = 1'b0;
    logic [63:0] s1_data = 64'h0;
    logic        m_valid, m_ready = 1'b1, m_last;
    logic [63:0] m_data;
    logic [1:0]  grant;

    int n_tests = 0;
    int n_fail  = 0;
    int vidx    = 0;
    logic [64:0] sb_q[$];

    typedef struct {
        logic        rst;
        logic        s0v, s0l;
        logic [63:0] s0d;
        logic        s1v, s1l;
        logic [63:0] s1d;
        logic        mr;
        logic        e_s0r, e_s1r, e_mv, e_ml;
        logic [63:0] e_md;
        logic [1:0]  e_g;
    } vec_t;

    vec_t vq[$];

    cmd_stream_arbiter #(.CMD_STREAM_WIDTH(64)) dut (
        .aclk(aclk), .resetn(resetn),
        .s0_cmd_axis_tvalid(s0_valid), .s0_cmd_axis_tready(s0_ready),
        .s0_cmd_axis_tlast(s0_last), .s0_cmd_axis_tdata(s0_data),
        .s1_cmd_axis_tvalid(s1_valid), .s1_cmd_axis_tready(s1_ready),
        .s1_cmd_axis_tlast(s1_last), .s1_cmd_axis_tdata(s1_data),
        .m_cmd_axis_tvalid(m_valid), .m_cmd_axis_tready(m_ready),
        .m_cmd_axis_tlast(m_last), .m_cmd_axis_tdata(m_data),
        .dbgGrant(grant)
    );

    always #5 aclk = ~aclk;

    function automatic vec_t mk(logic rst, logic s0v, logic s0l, logic [63:0] s0d,
                                logic s1v, logic s1l, logic [63:0] s1d, logic mr,
                                logic e_s0r, logic e_s1r, logic e_mv, logic e_ml,
                                logic [63:0] e_md, logic [1:0] e_g);
        vec_t v;
        v.rst = rst; v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
        v.s1v = s1v; v.s1l = s1l; v.s1d = s1d; v.mr = mr;
        v.e_s0r = e_s0r; v.e_s1r = e_s1r; v.e_mv = e_mv; v.e_ml = e_ml;
        v.e_md = e_md; v.e_g = e_g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, vidx, got, exp);
        end
    endtask

    // Scoreboard: every accepted source beat must leave on m in order, exactly once.
    always @(negedge aclk) begin
        if (!resetn) begin
            sb_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_beat", {63'd0, m_last}, 64'h1);
                end else begin
                    chk("sb_data", m_data, sb_q[0][63:0]);
                    chk("sb_last", {63'd0, m_last}, {63'd0, sb_q[0][64]});
                    void'(sb_q.pop_front());
                end
            end
            if (s0_valid && s0_ready) sb_q.push_back({s0_last, s0_data});
            if (s1_valid && s1_ready) sb_q.push_back({s1_last, s1_data});
        end
    end

    initial begin
        int beat;
        int seen;
        logic acc;
        logic out;

        // Test 1: reset state, then a 4-beat packet on port 0.
        vq.push_back(mk(H, L,L,64'h0,  L,L,64'h0, H, L,L, L,L,64'h0,  2'b00));
        vq.push_back(mk(L, H,L,64'h11, L,L,64'h0, H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,L,64'h11, L,L,64'h0, H, H,L, H,L,64'h11, 2'b01));
        vq.push_back(mk(L, H,L,64'h12, L,L,64'h0, H, H,L, H,L,64'h12, 2'b01));
        vq.push_back(mk(L, H,L,64'h13, L,L,64'h0, H, H,L, H,L,64'h13, 2'b01));
        vq.push_back(mk(L, H,H,64'h14, L,L,64'h0, H, H,L, H,H,64'h14, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  L,L,64'h0, H, L,L, L,L,64'h0,  2'b00));
        // Test 2: simultaneous requests after reset, then round-robin ties.
        vq.push_back(mk(H, L,L,64'h0,  L,L,64'h0,  H, L,L, L,L,64'h0,  2'b00));
        vq.push_back(mk(L, H,L,64'h21, H,L,64'h31, H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,L,64'h21, H,L,64'h31, H, H,L, H,L,64'h21, 2'b01));
        vq.push_back(mk(L, H,L,64'h22, H,L,64'h31, H, H,L, H,L,64'h22, 2'b01));
        vq.push_back(mk(L, H,H,64'h23, H,L,64'h31, H, H,L, H,H,64'h23, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'h31, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'h31, H, L,H, H,L,64'h31, 2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'h32, H, L,H, H,L,64'h32, 2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h33, H, L,H, H,H,64'h33, 2'b00));
        vq.push_back(mk(L, H,H,64'h41, H,H,64'h51, H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,H,64'h41, H,H,64'h51, H, H,L, H,H,64'h41, 2'b00));
        vq.push_back(mk(L, H,H,64'h42, H,H,64'h51, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, H,H,64'h42, H,H,64'h51, H, L,H, H,H,64'h51, 2'b00));
        vq.push_back(mk(L, H,H,64'h42, L,L,64'h0,  H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,H,64'h42, L,L,64'h0,  H, H,L, H,H,64'h42, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  L,L,64'h0,  H, L,L, L,L,64'h0,  2'b00));
        // Test 3: port 1 stalled behind a 5-beat port 0 packet with a valid gap.
        vq.push_back(mk(L, H,L,64'h61, L,L,64'h0,  H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,L,64'h61, L,L,64'h0,  H, H,L, H,L,64'h61, 2'b01));
        vq.push_back(mk(L, H,L,64'h62, L,L,64'h0,  H, H,L, H,L,64'h62, 2'b01));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h71, H, H,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,L,64'h63, H,H,64'h71, H, H,L, H,L,64'h63, 2'b01));
        vq.push_back(mk(L, H,L,64'h64, H,H,64'h71, H, H,L, H,L,64'h64, 2'b01));
        vq.push_back(mk(L, H,H,64'h65, H,H,64'h71, H, H,L, H,H,64'h65, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h71, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h71, H, L,H, H,H,64'h71, 2'b00));
        // Test 4: m_tready 1,0,0,1 mid-packet holds the output register.
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h81, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h81, H, L,H, H,L,64'h81, 2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h82, L, L,L, H,L,64'h81, 2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h82, L, L,L, H,L,64'h81, 2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h82, H, L,H, H,L,64'h82, 2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,L,64'h83, H, L,H, H,L,64'h83, 2'b10));
        vq.push_back(mk(L, L,L,64'h0, H,H,64'h84, H, L,H, H,H,64'h84, 2'b00));
        vq.push_back(mk(L, L,L,64'h0, L,L,64'h0,  L, L,L, H,H,64'h84, 2'b00));
        vq.push_back(mk(L, L,L,64'h0, L,L,64'h0,  H, L,L, L,L,64'h0,  2'b00));
        // Test 5: single-beat port 0 packet back-to-back with port 1.
        vq.push_back(mk(L, H,H,64'h91, H,H,64'h92, H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,H,64'h91, H,H,64'h92, H, H,L, H,H,64'h91, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h92, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'h92, H, L,H, H,H,64'h92, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  L,L,64'h0,  H, L,L, L,L,64'h0,  2'b00));
        // Test 6: port 0 wins last, reset mid port-1 packet, first tie goes to port 0.
        vq.push_back(mk(L, H,H,64'hA1, L,L,64'h0,  H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,H,64'hA1, L,L,64'h0,  H, H,L, H,H,64'hA1, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'hB1, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'hB1, H, L,H, H,L,64'hB1, 2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,L,64'hB2, H, L,H, H,L,64'hB2, 2'b10));
        vq.push_back(mk(H, L,L,64'h0,  H,L,64'hB3, H, L,L, L,L,64'h0,  2'b00));
        vq.push_back(mk(L, H,H,64'hC1, H,L,64'hB3, H, L,L, L,L,64'h0,  2'b01));
        vq.push_back(mk(L, H,H,64'hC1, H,H,64'hD1, H, H,L, H,H,64'hC1, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'hD1, H, L,L, L,L,64'h0,  2'b10));
        vq.push_back(mk(L, L,L,64'h0,  H,H,64'hD1, H, L,H, H,H,64'hD1, 2'b00));
        vq.push_back(mk(L, L,L,64'h0,  L,L,64'h0,  H, L,L, L,L,64'h0,  2'b00));

        #2;
        foreach (vq[i]) begin
            vidx     = i;
            resetn   = !vq[i].rst;
            s0_valid = vq[i].s0v; s0_last = vq[i].s0l; s0_data = vq[i].s0d;
            s1_valid = vq[i].s1v; s1_last = vq[i].s1l; s1_data = vq[i].s1d;
            m_ready  = vq[i].mr;
            #1;
            chk("s0_tready", {63'd0, s0_ready}, {63'd0, vq[i].e_s0r});
            chk("s1_tready", {63'd0, s1_ready}, {63'd0, vq[i].e_s1r});
            @(posedge aclk);
            #1;
            chk("m_tvalid", {63'd0, m_valid}, {63'd0, vq[i].e_mv});
            chk("dbgGrant", {62'd0, grant}, {62'd0, vq[i].e_g});
            if (vq[i].e_mv) begin
                chk("m_tdata", m_data, vq[i].e_md);
                chk("m_tlast", {63'd0, m_last}, {63'd0, vq[i].e_ml});
            end
        end

        // Six-beat port 1 packet under random backpressure, bounded by a cycle budget.
        vidx = -1;
        resetn = 1'b1;
        s0_valid = 1'b0;
        beat = 0;
        seen = 0;
        for (int c = 0; c < 300 && seen < 6; c++) begin
            s1_valid = (beat < 6);
            s1_data  = 64'hE0 + 64'(beat);
            s1_last  = (beat == 5);
            m_ready  = 1'($urandom_range(0, 1));
            #1;
            acc = s1_valid && s1_ready;
            out = m_valid && m_ready;
            @(posedge aclk);
            #1;
            if (acc) beat++;
            if (out) seen++;
        end
        chk("stall_run_beats_out", 64'(seen), 64'd6);
        s1_valid = 1'b0;
        m_ready  = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
